// File: rtl/tdc_spi_slave_ms1004.sv
// rtl/tdc_spi_slave_ms1004.sv - MS1004 TDC SPI responder; optional input synchronizer via TDC_SPI_SLV_SYNC_EN
module tdc_spi_slave_ms1004 #(
  parameter logic [7:0] WR_BASE = 8'h80,
  parameter logic [7:0] RD_BASE = 8'hB0
) (
  input  logic        clk,
  input  logic        i_rst_n,
  input  logic        i_spi_sck,
  input  logic        i_spi_ssn,
  input  logic        i_spi_si,
  output logic        o_spi_so,
  output logic        o_wr_valid,
  output logic [2:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_rd_req,
  output logic [2:0]  o_rd_addr,
  input  logic [31:0] i_rd_data,
  output logic        o_cmd_valid,
  output logic [7:0]  o_cmd_code,
  output logic        o_frame_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_OPCODE  = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_DATA = 3'd3;
  localparam logic [2:0] S_CMD     = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic        sck_q, ssn_q, si_q;
  logic        sck_q_d, ssn_q_d;
  logic [2:0]  state;
  logic [5:0]  bit_cnt;
  logic [30:0] sr;
  logic [2:0]  addr_q;
  logic [31:0] rd_sr;
  logic        rd_loaded;

  // Sync registers reset low so a frame already in progress at reset release
  // never produces a chip-select falling edge; ssn must be seen high first.
`ifdef TDC_SPI_SLV_SYNC_EN
  logic sck_m, ssn_m, si_m;

  // First synchronizer stage for the asynchronous master clock domain
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_m <= 1'b0;
      ssn_m <= 1'b0;
      si_m  <= 1'b0;
    end else begin
      sck_m <= i_spi_sck;
      ssn_m <= i_spi_ssn;
      si_m  <= i_spi_si;
    end
  end

  // Second synchronizer stage feeding edge detection
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_q <= 1'b0;
      ssn_q <= 1'b0;
      si_q  <= 1'b0;
    end else begin
      sck_q <= sck_m;
      ssn_q <= ssn_m;
      si_q  <= si_m;
    end
  end
`else
  // Single input register for the same-clock master
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_q <= 1'b0;
      ssn_q <= 1'b0;
      si_q  <= 1'b0;
    end else begin
      sck_q <= i_spi_sck;
      ssn_q <= i_spi_ssn;
      si_q  <= i_spi_si;
    end
  end
`endif

  // Delayed copies for edge detection
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sck_q_d <= 1'b0;
      ssn_q_d <= 1'b0;
    end else begin
      sck_q_d <= sck_q;
      ssn_q_d <= ssn_q;
    end
  end

  logic       sck_rise, sck_fall, ssn_rise, ssn_fall;
  logic [7:0] opcode, wr_off, rd_off;
  logic       is_wr, is_rd;

  assign sck_rise = sck_q & ~sck_q_d;
  assign sck_fall = ~sck_q & sck_q_d;
  assign ssn_rise = ssn_q & ~ssn_q_d;
  assign ssn_fall = ~ssn_q & ssn_q_d;

  assign opcode = {sr[6:0], si_q};
  assign wr_off = opcode - WR_BASE;
  assign rd_off = opcode - RD_BASE;
  assign is_wr  = (opcode >= WR_BASE) && (wr_off < 8'd8);
  assign is_rd  = (opcode >= RD_BASE) && (rd_off < 8'd8);

  // MISO is only driven while serving a read
  assign o_spi_so = (state == S_RD_DATA) && rd_loaded && rd_sr[31];

  // Frame state machine: bit capture, decode, frame-end checks and pulses
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      bit_cnt     <= 6'd0;
      sr          <= 31'd0;
      addr_q      <= 3'd0;
      rd_sr       <= 32'd0;
      rd_loaded   <= 1'b0;
      o_wr_valid  <= 1'b0;
      o_wr_addr   <= 3'd0;
      o_wr_data   <= 32'd0;
      o_rd_req    <= 1'b0;
      o_rd_addr   <= 3'd0;
      o_cmd_valid <= 1'b0;
      o_cmd_code  <= 8'd0;
      o_frame_err <= 1'b0;
    end else begin
      o_wr_valid  <= 1'b0;
      o_rd_req    <= 1'b0;
      o_cmd_valid <= 1'b0;
      o_frame_err <= 1'b0;
      if (ssn_rise) begin
        // Frame end wins over any coincident sck edge
        case (state)
          S_CMD: begin
            if (bit_cnt == 6'd8) begin
              o_cmd_valid <= 1'b1;
              o_cmd_code  <= sr[7:0];
            end else begin
              o_frame_err <= 1'b1;
            end
          end
          S_OPCODE:  o_frame_err <= 1'b1;
          S_WR_DATA: o_frame_err <= 1'b1;
          S_DONE:    o_frame_err <= (bit_cnt != 6'd40);
          default: ;
        endcase
        state     <= S_IDLE;
        rd_loaded <= 1'b0;
        o_rd_addr <= 3'd0;
      end else if (state == S_IDLE) begin
        if (ssn_fall) begin
          state   <= S_OPCODE;
          bit_cnt <= 6'd0;
          sr      <= 31'd0;
        end
      end else if (!ssn_q) begin
        if (sck_fall) begin
          bit_cnt <= (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;
          sr      <= {sr[29:0], si_q};
          if (state == S_OPCODE && bit_cnt == 6'd7) begin
            addr_q <= opcode[2:0];
            if (is_wr) begin
              state <= S_WR_DATA;
            end else if (is_rd) begin
              state     <= S_RD_DATA;
              o_rd_req  <= 1'b1;
              o_rd_addr <= opcode[2:0];
            end else begin
              state <= S_CMD;
            end
          end else if (state == S_WR_DATA && bit_cnt == 6'd39) begin
            o_wr_valid <= 1'b1;
            o_wr_addr  <= addr_q;
            o_wr_data  <= {sr, si_q};
            state      <= S_DONE;
          end
        end
        if (sck_rise && state == S_RD_DATA) begin
          if (!rd_loaded) begin
            rd_sr     <= i_rd_data;
            rd_loaded <= 1'b1;
          end else begin
            rd_sr <= {rd_sr[30:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_tdc_spi_slave_ms1004.sv
// tb/tb_tdc_spi_slave_ms1004.sv - self-checking bench for tdc_spi_slave_ms1004
module tb_tdc_spi_slave_ms1004;

  localparam int H = 2;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_spi_sck, i_spi_ssn, i_spi_si;
  logic        o_spi_so;
  logic        o_wr_valid;
  logic [2:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_rd_req;
  logic [2:0]  o_rd_addr;
  logic [31:0] i_rd_data;
  logic        o_cmd_valid;
  logic [7:0]  o_cmd_code;
  logic        o_frame_err;

  always #5 clk = ~clk;

  tdc_spi_slave_ms1004 dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_spi_sck  (i_spi_sck),
    .i_spi_ssn  (i_spi_ssn),
    .i_spi_si   (i_spi_si),
    .o_spi_so   (o_spi_so),
    .o_wr_valid (o_wr_valid),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_rd_req   (o_rd_req),
    .o_rd_addr  (o_rd_addr),
    .i_rd_data  (i_rd_data),
    .o_cmd_valid(o_cmd_valid),
    .o_cmd_code (o_cmd_code),
    .o_frame_err(o_frame_err)
  );

  int checks = 0;
  int errors = 0;

  int          n_wr, n_err, n_cmd, n_rd;
  logic [2:0]  got_wr_addr, got_rd_addr;
  logic [31:0] got_wr_data;
  logic [7:0]  got_cmd;
  logic [31:0] host_mem [8];
  logic [39:0] last_miso;

  // Pulse monitor and read-data host
  always @(negedge clk) begin
    if (o_wr_valid) begin
      n_wr++;
      got_wr_addr = o_wr_addr;
      got_wr_data = o_wr_data;
    end
    if (o_frame_err) n_err++;
    if (o_cmd_valid) begin
      n_cmd++;
      got_cmd = o_cmd_code;
    end
    if (o_rd_req) begin
      n_rd++;
      got_rd_addr = o_rd_addr;
      i_rd_data = host_mem[o_rd_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    n_wr = 0; n_err = 0; n_cmd = 0; n_rd = 0;
  endtask

  task automatic spi_bit(input logic b, output logic so);
    i_spi_sck = 1'b1;
    i_spi_si  = b;
    repeat (H) @(negedge clk);
    so = o_spi_so;
    i_spi_sck = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  // Drives one frame and checks it against the protocol rules
  task automatic do_frame(input string tag, input logic [7:0] op, input logic [31:0] data, input int nbits);
    logic [39:0] bits, miso, exp_miso;
    logic so, b;
    logic [31:0] rword;
    bit is_wr, is_rd;
    int e_wr, e_err, e_cmd, e_rd, ncap;
    bits = {op, data};
    miso = '0;
    exp_miso = '0;
    clear_counts();
    i_spi_ssn = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      spi_bit((i < 40) ? bits[39-i] : 1'b0, so);
      if (i < 40) miso = {miso[38:0], so};
    end
    repeat (H) @(negedge clk);
    i_spi_ssn = 1'b1;
    repeat (4) @(negedge clk);
    last_miso = miso;

    is_wr = (op >= 8'h80) && (op <= 8'h87);
    is_rd = (op >= 8'hB0) && (op <= 8'hB7);
    e_wr = 0; e_err = 0; e_cmd = 0; e_rd = 0;
    if (nbits < 8) e_err = 1;
    else if (is_wr) begin
      if (nbits >= 40) e_wr = 1;
      if (nbits != 40) e_err = 1;
    end else if (is_rd) e_rd = 1;
    else if (nbits == 8) e_cmd = 1;
    else e_err = 1;

    rword = host_mem[op[2:0]];
    ncap = (nbits < 40) ? nbits : 40;
    for (int i = 0; i < ncap; i++) begin
      b = (e_rd == 1 && i >= 8) ? rword[39-i] : 1'b0;
      exp_miso = {exp_miso[38:0], b};
    end

    check({tag, " wr_pulses"}, n_wr, e_wr);
    check({tag, " err_pulses"}, n_err, e_err);
    check({tag, " cmd_pulses"}, n_cmd, e_cmd);
    check({tag, " rd_pulses"}, n_rd, e_rd);
    if (e_wr == 1) begin
      check({tag, " wr_addr"}, got_wr_addr, op[2:0]);
      check({tag, " wr_data"}, got_wr_data, data);
    end
    if (e_cmd == 1) check({tag, " cmd_code"}, got_cmd, op);
    if (e_rd == 1) begin
      check({tag, " rd_addr"}, got_rd_addr, op[2:0]);
      check({tag, " miso"}, miso, exp_miso);
    end
    check({tag, " so_idle"}, o_spi_so, 1'b0);
  endtask

  initial begin
    logic so;
    logic [7:0] op;
    logic [7:0] rst_op;
    logic [23:0] m24;
    int nb;
    i_rst_n   = 1'b0;
    i_spi_sck = 1'b0;
    i_spi_ssn = 1'b1;
    i_spi_si  = 1'b0;
    i_rd_data = 32'd0;
    for (int i = 0; i < 8; i++) host_mem[i] = $urandom;
    clear_counts();
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {o_spi_so, o_wr_valid, o_wr_addr, o_wr_data, o_rd_req, o_rd_addr, o_cmd_valid, o_cmd_code, o_frame_err},
          51'd0);
    i_rst_n = 1'b1;
    repeat (3) @(negedge clk);

    do_frame("wr83", 8'h83, 32'hDEADBEEF, 40);
    check("wr83_data_const", got_wr_data, 32'hDEADBEEF);

    host_mem[5] = 32'h12345678;
    do_frame("rdB5", 8'hB5, 32'd0, 32);
    m24 = last_miso[23:0];
    check("rdB5_24bits", m24, 24'h123456);

    do_frame("cmd70", 8'h70, 32'd0, 8);
    do_frame("cmd70_extra", 8'h70, 32'd0, 10);
    do_frame("wr80_short", 8'h80, 32'hFFFF_FFFF, 28);
    do_frame("wr81", 8'h81, 32'h0000_0001, 40);
    do_frame("short_op", 8'h83, 32'd0, 5);

    // Reset in the middle of a read, after 10 bits
    rst_op = 8'hB5;
    clear_counts();
    i_spi_ssn = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) spi_bit((i < 8) ? rst_op[7-i] : 1'b1, so);
    i_rst_n = 1'b0;
    #1;
    check("midread_reset_outputs",
          {o_spi_so, o_wr_valid, o_wr_addr, o_wr_data, o_rd_req, o_rd_addr, o_cmd_valid, o_cmd_code, o_frame_err},
          51'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    clear_counts();
    for (int i = 0; i < 6; i++) spi_bit(1'b1, so);
    i_spi_ssn = 1'b1;
    repeat (4) @(negedge clk);
    check("after_reset_quiet", n_wr + n_err + n_cmd + n_rd, 0);
    host_mem[0] = $urandom;
    do_frame("rdB0_after_reset", 8'hB0, 32'd0, 40);

    // Randomized frames
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0: op = 8'h80 + 8'($urandom_range(0, 7));
        1: op = 8'hB0 + 8'($urandom_range(0, 7));
        2: op = 8'($urandom);
        default: op = 8'h70;
      endcase
      case ($urandom_range(0, 4))
        0: nb = $urandom_range(1, 7);
        1: nb = 8;
        2: nb = $urandom_range(9, 39);
        3: nb = 40;
        default: nb = $urandom_range(41, 44);
      endcase
      do_frame($sformatf("rand%0d_op%02h_n%0d", k, op, nb), op, $urandom, nb);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
